// File: rtl/jtpopeye_sync_if.sv
// Bus between the timing generator (master) and the sync receiver (slave).
// The master drives pixel enable and blanking and observes the sync, position and lock results.
interface jtpopeye_sync_if;
    logic       pxl_cen;
    logic       HB;
    logic       VB;
    logic       HS;
    logic       VS;
    logic [8:0] hcnt;
    logic [8:0] vcnt;
    logic [8:0] h_total;
    logic [8:0] v_total;
    logic       locked;
    logic [7:0] err_cnt;

    modport master (
        output pxl_cen, HB, VB,
        input  HS, VS, hcnt, vcnt, h_total, v_total, locked, err_cnt
    );

    modport slave (
        input  pxl_cen, HB, VB,
        output HS, VS, hcnt, vcnt, h_total, v_total, locked, err_cnt
    );
endinterface

// File: rtl/jtpopeye_sync.sv
// Video timing receiver. It follows HB/VB from the timing generator, rebuilds the pixel and
// line position, measures line and frame length, regenerates HS/VS and reports lock.
// Optional macro JTPOPEYE_SYNC_STATS_EN adds a saturating lock-loss counter on err_cnt;
// without it err_cnt is constant zero.
module jtpopeye_sync #(
    parameter logic [8:0] HS_START    = 9'd16,
    parameter logic [8:0] HS_LEN      = 9'd32,
    parameter logic [8:0] VS_START    = 9'd4,
    parameter logic [8:0] VS_LEN      = 9'd3,
    parameter logic [3:0] LOCK_FRAMES = 4'd2
) (
    input  logic             clk,
    input  logic             rst_n,
    jtpopeye_sync_if.slave   bus
);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    // HS is high while hcnt is in [HS_START, HS_START+HS_LEN); the register changes one tick early.
    localparam logic [8:0] HS_SET = HS_START - 9'd1;
    localparam logic [8:0] HS_CLR = HS_START + HS_LEN - 9'd1;
    localparam logic [8:0] VS_CLR = VS_START + VS_LEN;

    state_t     state, state_nx;
    logic [3:0] good, good_nx;
    logic       hbl, vbl, mismatch;
    logic       hs, hs_nx, vs, vs_nx, locked;
    logic [8:0] hcnt, vcnt, h_total, v_total;
    logic [8:0] hcnt_inc, vcnt_inc;
    logic       hb_rise, frame_start, timeout;

    assign hcnt_inc    = hcnt + 9'd1;
    assign vcnt_inc    = vcnt + 9'd1;
    assign hb_rise     = bus.pxl_cen & bus.HB & ~hbl;
    assign frame_start = hb_rise & bus.VB & ~vbl;
    // Lost HB edges: the tick that would take hcnt to its ceiling. A coincident HB rise wins.
    assign timeout     = bus.pxl_cen & ~hb_rise & (hcnt == 9'd510);

    // Position counters, line/frame measurement and line-length mismatch tracking.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hbl      <= 1'b0;
            vbl      <= 1'b0;
            hcnt     <= 9'd0;
            vcnt     <= 9'd0;
            h_total  <= 9'd0;
            v_total  <= 9'd0;
            mismatch <= 1'b0;
        end else if (bus.pxl_cen) begin
            hbl <= bus.HB;
            if (hb_rise) begin
                hcnt    <= 9'd0;
                h_total <= hcnt_inc;
                vbl     <= bus.VB;
                if (frame_start) begin
                    vcnt     <= 9'd0;
                    v_total  <= vcnt_inc;
                    mismatch <= 1'b0;
                end else begin
                    vcnt <= vcnt_inc;
                    if (hcnt_inc != h_total) mismatch <= 1'b1;
                end
            end else if (hcnt != 9'h1ff) begin
                hcnt <= hcnt_inc;
            end
        end
    end

    // Lock FSM decisions plus next HS/VS levels.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        good_nx  = good;
        hs_nx    = hs;
        vs_nx    = vs;

        if (timeout) begin
            state_nx = SEARCH;
            good_nx  = 4'd0;
        end else if (frame_start) begin
            case (state)
                SEARCH: begin
                    state_nx = TRACK;
                    good_nx  = 4'd0;
                end
                TRACK: begin
                    if (!mismatch && vcnt_inc == v_total) begin
                        good_nx = good + 4'd1;
                        if (good_nx >= LOCK_FRAMES) state_nx = LOCKED;
                    end else begin
                        good_nx = 4'd0;
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        state_nx = TRACK;
                        good_nx  = 4'd0;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end

        if (hb_rise)                                hs_nx = 1'b0;
        else if (bus.pxl_cen && hcnt == HS_SET)     hs_nx = 1'b1;
        else if (bus.pxl_cen && hcnt == HS_CLR)     hs_nx = 1'b0;

        if (frame_start)                            vs_nx = 1'b0;
        else if (hb_rise && vcnt_inc == VS_START)   vs_nx = 1'b1;
        else if (hb_rise && vcnt_inc == VS_CLR)     vs_nx = 1'b0;

        // Syncs are suppressed in SEARCH and cut on the very tick SEARCH is entered.
        if (state_nx == SEARCH) begin
            hs_nx = 1'b0;
            vs_nx = 1'b0;
        end
    end

    // State, good-frame count and sync registers; locked trails the state by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SEARCH;
            good   <= 4'd0;
            hs     <= 1'b0;
            vs     <= 1'b0;
            locked <= 1'b0;
        end else begin
            if (bus.pxl_cen) begin
                state <= state_nx;
                good  <= good_nx;
                hs    <= hs_nx;
                vs    <= vs_nx;
            end
            locked <= (state == LOCKED);
        end
    end

`ifdef JTPOPEYE_SYNC_STATS_EN
    logic [7:0] err_cnt;
    logic       lock_loss;

    assign lock_loss = (state == LOCKED) & (timeout | (frame_start & mismatch));

    // Saturating count of LOCKED exits; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             err_cnt <= 8'd0;
        else if (lock_loss && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
    end

    assign bus.err_cnt = err_cnt;
`else
    assign bus.err_cnt = 8'd0;
`endif

    assign bus.HS      = hs;
    assign bus.VS      = vs;
    assign bus.hcnt    = hcnt;
    assign bus.vcnt    = vcnt;
    assign bus.h_total = h_total;
    assign bus.v_total = v_total;
    assign bus.locked  = locked;

endmodule

// File: tb/tb_jtpopeye_sync.sv
// Directed bench for jtpopeye_sync: 384-tick lines (HB high 128, low 256), 10-line frames
// with VB high on line 0, so a full lock sequence fits a short run.
module tb_jtpopeye_sync;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

`ifdef JTPOPEYE_SYNC_STATS_EN
    localparam logic [8:0] ERR1 = 9'd1;
    localparam logic [8:0] ERR2 = 9'd2;
`else
    localparam logic [8:0] ERR1 = 9'd0;
    localparam logic [8:0] ERR2 = 9'd0;
`endif

    jtpopeye_sync_if bus ();

    jtpopeye_sync dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hcnt"},    bus.hcnt,           9'd0);
        check({tag, "_vcnt"},    bus.vcnt,           9'd0);
        check({tag, "_h_total"}, bus.h_total,        9'd0);
        check({tag, "_v_total"}, bus.v_total,        9'd0);
        check({tag, "_hs"},      9'(bus.HS),         9'd0);
        check({tag, "_vs"},      9'(bus.VS),         9'd0);
        check({tag, "_locked"},  9'(bus.locked),     9'd0);
        check({tag, "_err_cnt"}, 9'(bus.err_cnt),    9'd0);
    endtask

    // One pixel tick: inputs settle between edges, outputs are read 1 time unit after the edge.
    task automatic tick(input logic hb, input logic vb);
        bus.pxl_cen = 1'b1;
        bus.HB      = hb;
        bus.VB      = vb;
        @(posedge clk);
        #1;
    endtask

    // Ticks start..len-1 of a line; tick 0 is the HB rise. Optionally checks HS edges.
    task automatic run_line(input int len, input logic vb, input bit chk_hs, input int start);
        for (int t = start; t < len; t++) begin
            tick(t < 128, vb);
            if (chk_hs) begin
                if (t == 15) check("hs_low_at_15",  9'(bus.HS), 9'd0);
                if (t == 16) check("hs_high_at_16", 9'(bus.HS), 9'd1);
                if (t == 16) check("hcnt_at_16",    bus.hcnt,   9'd16);
                if (t == 47) check("hs_high_at_47", 9'(bus.HS), 9'd1);
                if (t == 48) check("hs_low_at_48",  9'(bus.HS), 9'd0);
            end
        end
    endtask

    // Rest of a frame from tick `start` of line 0. chk adds HS and per-line VS/vcnt checks.
    task automatic run_frame_from(input int start, input bit chk, input int jitter_line);
        run_line(384, 1'b1, 1'b0, start);
        if (chk) check("vs_line0", 9'(bus.VS), 9'd0);
        for (int l = 1; l < 10; l++) begin
            run_line((l == jitter_line) ? 385 : 384, 1'b0, chk && l == 1, 0);
            if (chk) begin
                check("vcnt_line", bus.vcnt, 9'(l));
                check("vs_line",   9'(bus.VS), (l >= 4 && l < 7) ? 9'd1 : 9'd0);
            end
        end
    endtask

    task automatic preamble();
        for (int l = 1; l < 10; l++) run_line(384, 1'b0, 1'b0, 0);
    endtask

    initial begin
        bus.pxl_cen = 1'b0;
        bus.HB      = 1'b0;
        bus.VB      = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Enter mid-frame: nine lines without VB
        preamble();
        check("pre_h_total", bus.h_total,     9'd384);
        check("pre_vcnt",    bus.vcnt,        9'd9);
        check("pre_hcnt",    bus.hcnt,        9'd383);
        check("pre_locked",  9'(bus.locked),  9'd0);

        // Frame A: VB and HB rise together -> frame start, SEARCH -> TRACK
        tick(1'b1, 1'b1);
        check("a_vcnt",    bus.vcnt,    9'd0);
        check("a_v_total", bus.v_total, 9'd10);
        check("a_hcnt",    bus.hcnt,    9'd0);
        // pxl_cen low: nothing moves, HB toggle is ignored
        bus.pxl_cen = 1'b0;
        bus.HB      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cen_hcnt", bus.hcnt, 9'd0);
        check("cen_vcnt", bus.vcnt, 9'd0);
        run_frame_from(1, 1'b0, -1);

        // Frame B: first good frame
        tick(1'b1, 1'b1);
        check("b_locked", 9'(bus.locked), 9'd0);
        run_frame_from(1, 1'b0, -1);

        // Frame C: second good frame -> LOCKED, locked follows one clk later
        tick(1'b1, 1'b1);
        check("c_locked_same_clk", 9'(bus.locked), 9'd0);
        tick(1'b1, 1'b1);
        check("c_locked_next_clk", 9'(bus.locked), 9'd1);
        check("c_h_total",         bus.h_total,    9'd384);
        run_frame_from(2, 1'b1, -1);

        // Frame D: line 3 is 385 ticks
        tick(1'b1, 1'b1);
        run_frame_from(1, 1'b0, 3);
        check("d_locked",  9'(bus.locked),  9'd1);
        check("d_err_cnt", 9'(bus.err_cnt), 9'd0);

        // Frame E: mismatch seen at frame start -> TRACK, lock-loss event
        tick(1'b1, 1'b1);
        check("e_locked_same_clk", 9'(bus.locked),  9'd1);
        check("e_err_cnt",         9'(bus.err_cnt), ERR1);
        tick(1'b1, 1'b1);
        check("e_locked_next_clk", 9'(bus.locked),  9'd0);
        run_frame_from(2, 1'b0, -1);

        // Frame F: good=1
        tick(1'b1, 1'b1);
        check("f_locked", 9'(bus.locked), 9'd0);
        run_frame_from(1, 1'b0, -1);

        // Frame G: relocked two frames after the drop
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("g_relocked", 9'(bus.locked), 9'd1);
        run_frame_from(2, 1'b0, -1);

        // Frame H: HB stalls low 600 ticks in line 5, while VS is active
        tick(1'b1, 1'b1);
        run_line(384, 1'b1, 1'b0, 1);
        for (int l = 1; l < 5; l++) run_line(384, 1'b0, 1'b0, 0);
        for (int t = 0; t < 728; t++) begin
            tick(t < 128, 1'b0);
            if (t == 510) begin
                check("stall_hcnt_510",  bus.hcnt,       9'd510);
                check("stall_vs_before", 9'(bus.VS),     9'd1);
                check("stall_locked_pre",9'(bus.locked), 9'd1);
            end
            if (t == 511) begin
                check("stall_hcnt_511",  bus.hcnt,        9'd511);
                check("stall_vs_cut",    9'(bus.VS),      9'd0);
                check("stall_hs",        9'(bus.HS),      9'd0);
                check("stall_err_cnt",   9'(bus.err_cnt), ERR2);
            end
            if (t == 512) check("stall_locked", 9'(bus.locked), 9'd0);
        end
        check("stall_hcnt_sat", bus.hcnt, 9'd511);

        // SEARCH: no HS even at HS position
        for (int t = 0; t < 384; t++) begin
            tick(t < 128, 1'b0);
            if (t == 20) check("search_hs", 9'(bus.HS), 9'd0);
        end
        for (int l = 7; l < 10; l++) run_line(384, 1'b0, 1'b0, 0);

        // Frames J, K, L: relock
        tick(1'b1, 1'b1);
        check("j_v_total", bus.v_total, 9'd10);
        run_frame_from(1, 1'b0, -1);
        tick(1'b1, 1'b1);
        run_frame_from(1, 1'b0, -1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("l_locked", 9'(bus.locked), 9'd1);
        run_line(384, 1'b1, 1'b0, 2);
        run_line(21, 1'b0, 1'b0, 0);
        check("pre_reset_hs", 9'(bus.HS), 9'd1);

        // Asynchronous reset in the middle of HS
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        bus.pxl_cen = 1'b0;
        bus.HB      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Relock from scratch: SEARCH -> TRACK -> good -> LOCKED
        preamble();
        check("post_rst_hs", 9'(bus.HS), 9'd0);
        tick(1'b1, 1'b1);
        run_frame_from(1, 1'b0, -1);
        tick(1'b1, 1'b1);
        check("b2_locked", 9'(bus.locked), 9'd0);
        run_frame_from(1, 1'b0, -1);
        tick(1'b1, 1'b1);
        check("c2_locked_same_clk", 9'(bus.locked), 9'd0);
        tick(1'b1, 1'b1);
        check("c2_locked",  9'(bus.locked),  9'd1);
        check("c2_err_cnt", 9'(bus.err_cnt), 9'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
